// File: rtl/alu_issue_stage.sv
// alu_issue_stage: MIPS R/I-type decode and issue into the ID/EX register feeding the ALU.
// Define ISSUE_ILLEGAL_TRAP_EN to add the illegalInstr trap output for unsupported words.
module alu_issue_stage #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instValid,
    output logic              instReady,
    input  logic [31:0]       instWord,
    output logic              exValid,
    output logic [1:0]        exAluOp,
    output logic [5:0]        exFunct,
    output logic [4:0]        exShamt,
    output logic [5:0]        exOpCode,
    output logic [DATA_W-1:0] exInput1,
    output logic [DATA_W-1:0] exInput2,
    output logic [4:0]        exDest,
    input  logic              wbEn,
    input  logic [4:0]        wbAddr,
    input  logic [DATA_W-1:0] wbData,
    input  logic              aluOverflow
`ifdef ISSUE_ILLEGAL_TRAP_EN
    ,
    output logic              illegalInstr
`endif
);

    typedef struct packed {
        logic [1:0]        alu_op;
        logic [5:0]        funct;
        logic [4:0]        shamt;
        logic [5:0]        op;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [4:0]        dest;
    } ex_t;

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    ex_t  ex_q, ex_d;
    logic ex_valid_q, ex_valid_d;
    logic recover_q, recover_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic is_r, is_shift, is_addi, is_andi, supported;
    logic need_rs, need_rt, rs_byp, rt_byp, hazard, ovf, issue, trap_block;
    logic [DATA_W-1:0] rs_val, rt_val;

    assign op    = instWord[31:26];
    assign rs    = instWord[25:21];
    assign rt    = instWord[20:16];
    assign rd    = instWord[15:11];
    assign shamt = instWord[10:6];
    assign funct = instWord[5:0];
    assign imm   = instWord[15:0];

    always_comb begin
        is_r     = 1'b0;
        is_shift = 1'b0;
        if (op == 6'd0) begin
            case (funct)
                6'd0, 6'd2, 6'd3: begin
                    is_r     = 1'b1;
                    is_shift = 1'b1;
                end
                6'd32, 6'd34, 6'd36, 6'd37, 6'd42: is_r = 1'b1;
                default: ;
            endcase
        end
        is_addi   = (op == 6'd8);
        is_andi   = (op == 6'd12);
        supported = is_r | is_addi | is_andi;
        // Shifts take their operand from rt; rs is a don't-care for them.
        need_rs   = (is_r & ~is_shift) | is_addi | is_andi;
        need_rt   = is_r;
    end

    always_comb begin
        rs_byp = wbEn && (wbAddr == rs);
        rt_byp = wbEn && (wbAddr == rt);
        rs_val = rs_byp ? wbData : rf_q[rs];
        rt_val = rt_byp ? wbData : rf_q[rt];
        if (rs == 5'd0) rs_val = '0;
        if (rt == 5'd0) rt_val = '0;
    end

    assign ovf    = aluOverflow && ex_valid_q;
    assign hazard = (need_rs && pend_q[rs] && !rs_byp)
                  | (need_rt && pend_q[rt] && !rt_byp);
    assign instReady = !hazard && !recover_q && !ovf && !trap_block;
    assign issue     = instValid && instReady && supported;

    always_comb begin
        rf_d       = rf_q;
        pend_d     = pend_q;
        ex_d       = ex_q;
        ex_valid_d = issue;
        recover_d  = ovf;
        if (wbEn) begin
            pend_d[wbAddr] = 1'b0;
            if (wbAddr != 5'd0) rf_d[wbAddr] = wbData;
        end
        if (ovf) pend_d = '0;
        if (issue) begin
            ex_d.alu_op = is_addi ? 2'd0 : (is_andi ? 2'd1 : 2'd2);
            ex_d.funct  = is_r ? funct : 6'd0;
            ex_d.shamt  = shamt;
            ex_d.op     = op;
            ex_d.in1    = is_shift ? rt_val : rs_val;
            if (is_r)
                ex_d.in2 = rt_val;
            else if (is_addi)
                ex_d.in2 = {{(DATA_W-16){imm[15]}}, imm};
            else
                ex_d.in2 = {{(DATA_W-16){1'b0}}, imm};
            ex_d.dest   = is_r ? rd : rt;
            if (ex_d.dest != 5'd0) pend_d[ex_d.dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            pend_q     <= '0;
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            recover_q  <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            pend_q     <= pend_d;
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            recover_q  <= recover_d;
        end
    end

`ifdef ISSUE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d, blocked_q, blocked_d;

    always_comb begin
        illegal_d = instValid && instReady && !supported;
        blocked_d = blocked_q | illegal_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            blocked_q <= blocked_d;
        end
    end

    assign illegalInstr = illegal_q;
    assign trap_block   = blocked_q;
`else
    assign trap_block = 1'b0;
`endif

    assign exValid  = ex_valid_q;
    assign exAluOp  = ex_q.alu_op;
    assign exFunct  = ex_q.funct;
    assign exShamt  = ex_q.shamt;
    assign exOpCode = ex_q.op;
    assign exInput1 = ex_q.in1;
    assign exInput2 = ex_q.in2;
    assign exDest   = ex_q.dest;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage directly upstream of the 32-bit ALU and its control decoder. It accepts MIPS R-type and I-type instruction words over a valid/ready handshake, reads operands from an internal 32x32 register file, and builds the immediate. It then registers aluOp, funct, shamt, the operands and the opcode into an ID/EX register that drives the ALU. A per-register pending scoreboard stalls RAW hazards until writeback, and an ALU overflow flushes the in-flight state.

Parameters:
NUM_REGS, 32, register file depth; r0 is hardwired to zero.
DATA_W, 32, operand and result width.

Ports:
clk  input  1  rising-edge clock for all state.
rst  input  1  synchronous reset, active-high; sampled on the clk rising edge.
instValid  input  1  instruction word present.
instReady  output  1  stage accepts instWord this cycle.
instWord  input  32  MIPS instruction: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0].
exValid  output  1  ID/EX register holds an instruction for the ALU this cycle.
exAluOp  output  2  0 = ADDI (add), 1 = ANDI (and), 2 = R-type (use funct).
exFunct  output  6  funct field; 0 for I-type.
exShamt  output  5  shamt field.
exOpCode  output  6  opcode field.
exInput1  output  32  rs value.
exInput2  output  32  rt value (R-type) or extended immediate (I-type).
exDest  output  5  destination register: rd for R-type, rt for I-type.
wbEn  input  1  writeback strobe.
wbAddr  input  5  writeback register.
wbData  input  32  writeback data.
aluOverflow  input  1  ALU reports overflow on the instruction currently in EX.

Behaviour:
- Reset: all outputs 0 except instReady = 1. All pending bits cleared. Register file contents are cleared to 0.
- Supported instructions:
  - op = 0 with funct in {0 SLL, 2 SRL, 3 SRA, 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT} issues exAluOp = 2.
  - op = 8 (ADDI) issues exAluOp = 0 with imm sign-extended.
  - op = 12 (ANDI) issues exAluOp = 1 with imm zero-extended.
  - Anything else is unsupported (see Optional Feature).
- Sources:
  - R-type reads rs and rt; shifts read rt only (exInput1 = rt value for SLL/SRL/SRA).
  - I-type reads rs.
- Register file read:
  - Combinational from current contents.
  - If wbEn and wbAddr equal a source register in the same cycle, wbData is bypassed.
  - r0 always reads 0 and is never marked pending.
- Hazard:
  - instReady = 0 when any needed source has its pending bit set (excluding any bypassed this cycle), or during the overflow recovery cycle.
  - Otherwise instReady = 1.
- Issue: on instValid && instReady with a supported instruction, the ID/EX register loads on the next edge; exValid = 1 for exactly that cycle (1-cycle latency). It also sets pending[exDest] unless exDest = 0.
- Idle: if no issue occurs, exValid = 0 next cycle; the other ex* outputs hold their previous values.
- Writeback: wbEn writes regfile[wbAddr] (ignored for 0) and clears pending[wbAddr]. A clear and a set to the same register in the same cycle resolves to set.
- Overflow: aluOverflow with exValid causes the following:
  - On the next edge all pending bits clear and exValid = 0.
  - No issue occurs in that cycle or the following cycle (instReady = 0 for one cycle).
  - The downstream writeback stage suppresses the overflowed write.
- Reset mid-operation overrides issue, writeback and overflow in the same cycle.

Optional Feature:
ISSUE_ILLEGAL_TRAP_EN:
- Defined: adds output illegalInstr (1 bit, reset 0). An accepted unsupported word pulses illegalInstr = 1 for one cycle, and issue then blocks (instReady = 0) until rst.
- Undefined: unsupported words are accepted and silently dropped (no exValid, no pending change); the port is absent.

Test Plan:
- Reset then write r1 = 5, r2 = 7 via wb; issue ADD r3,r1,r2 (funct 32) -> next cycle exValid = 1, exAluOp = 2, exFunct = 32, exInput1 = 5, exInput2 = 7, exDest = 3, pending[3] = 1.
- ADDI r4,r1,0xFFFF -> exAluOp = 0, exInput2 = 0xFFFFFFFF. ANDI r4,r1,0xFFFF -> exAluOp = 1, exInput2 = 0x0000FFFF.
- ADD r3 then SUB r5,r3,r1 back-to-back -> instReady = 0 until wbEn with wbAddr = 3, wbData = 12. In that bypass cycle the SUB is accepted, with exInput1 = 12 the next cycle.
- SLL r6,r2,shamt 4 -> exInput1 = 7, exShamt = 4, exFunct = 0; source rs is ignored even when it is pending.
- Issue ADD r7, then assert aluOverflow in the EX cycle -> pending[7] = 0, exValid = 0, instReady = 0 for one cycle, then 1.
- Issue with rd = 0 -> no pending set. Assert rst together with instValid -> no issue, all outputs at reset values.
